life_hud_drawer: RTL and testbench
==================================

Name: life_hud_drawer

Overview:
- Upstream and downstream companion of the life-icon sprite ROM; one instance drives the HUD's remaining-lives row.
- Maps the VGA scan position (DrawX/DrawY) onto up to MAX_LIVES icon slots and generates the ROM read address.
- Consumes the ROM's palette-decoded 24-bit colour and applies transparency keying.
- Produces an aligned pixel_on/pixel_rgb pair for the colour mapper, and blinks recently lost lives for a fixed number of frames.

Parameters:
- ICON_W, 40: icon width in pixels.
- ICON_H, 39: icon height in pixels. ICON_W*ICON_H = 1560 = ROM depth.
- ICON_X0, 16: left x of slot 0.
- ICON_Y0, 8: top y of all slots.
- ICON_GAP, 8: horizontal gap between slots. Pitch = ICON_W + ICON_GAP = 48.
- MAX_LIVES, 3: number of slots.
- BLINK_FRAMES, 64: frames a lost icon blinks.
- BLINK_SHIFT, 3: blink phase = frame counter bit BLINK_SHIFT (toggles every 8 frames).
- TRANSPARENT, 24'hFFFFFF: colour key treated as not-drawn.

Ports:
- Clk, in, 1: pixel clock.
- Reset, in, 1: asynchronous, active-high.
- frame_start, in, 1: one-cycle pulse at start of vertical blank.
- lives, in, 3: current life count from game logic; values above MAX_LIVES are clamped.
- DrawX, in, 10: current pixel x.
- DrawY, in, 10: current pixel y.
- rom_addr, out, 11: ROM read address (combinational).
- rom_data, in, 24: ROM colour output, valid 1 clock after rom_addr.
- pixel_on, out, 1: HUD pixel opaque this cycle (registered).
- pixel_rgb, out, 24: HUD colour (registered).
- blinking, out, 1: blink sequence active (registered).

Behaviour:
- Reset (async): pixel_on=0, pixel_rgb=0, blinking=0, lives_q=0, old_q=0, frame counter=0, state=IDLE.
- Stage 0 (comb):
  - slot k hits iff DrawY in [ICON_Y0, ICON_Y0+ICON_H) and DrawX in [ICON_X0+k*48, ICON_X0+k*48+ICON_W).
  - row = DrawY-ICON_Y0; col = DrawX-slot_x.
  - rom_addr = row*40+col, built as (row<<5)+(row<<3)+col, 11-bit; maximum value 1559.
  - No hit: rom_addr=0.
  - Gap pixels never hit.
- Stage 1 (reg): latch hit and visible(k) evaluated in stage 0, aligned with rom_data.
- Output (reg): pixel_on <= hit_d1 & visible_d1 & (rom_data != TRANSPARENT); pixel_rgb <= pixel_on-next ? rom_data : 0.
- Total latency DrawX/DrawY -> pixel_on/pixel_rgb = 2 clocks. The colour mapper delays its own coordinates by 2.
- Visibility:
  - visible(k) = (k < lives_q) | (state==BLINK & k >= lives_q & k < old_q & phase).
  - phase = cnt[BLINK_SHIFT] inverted, so the lost icon shows during the first 8 frames.
- lives_q, old_q, state and cnt update only on frame_start, so there is no mid-frame tearing.
- FSM (on frame_start, with L = min(lives, MAX_LIVES)):
  - IDLE, L<lives_q: old_q<=lives_q, lives_q<=L, cnt<=0, go to BLINK.
  - IDLE, otherwise: lives_q<=L.
  - BLINK, L<lives_q: further loss; restart with old_q<=old_q (the blink range widens), lives_q<=L, cnt<=0.
  - BLINK, L>lives_q: gain; lives_q<=L, go to IDLE (blink aborted).
  - BLINK, L==lives_q and cnt==BLINK_FRAMES-1: go to IDLE, cnt<=0.
  - BLINK, otherwise: cnt<=cnt+1.
- blinking <= (state==BLINK).
- First frame_start after reset loads lives with no blink, since it is an increase from 0.
- frame_start coinciding with an in-slot pixel: the new state affects pixels from the next cycle only. This never happens in practice because frame_start arrives during blank.
- Reset mid-pipeline flushes both stages; no stale pixel_on appears after release.

Decomposition:
- Package hud_pkg holds:
  - ICON_W, ICON_H, ICON_PITCH, TRANSPARENT;
  - typedef enum logic {IDLE, BLINK} blink_state_t;
  - a function slot_x(k).
- Sub-module life_blink_ctrl owns the FSM, cnt, lives_q and old_q, and exports lives_q, old_q, phase and blinking.
- The drawer keeps the address generation and the 2-stage pixel pipeline.

Test Plan:
- Reset, frame_start with lives=3, DrawY=8, DrawX=16 -> rom_addr=0; pixel_on tracks rom_data!=FFFFFF 2 clocks later. DrawX=64 (slot 1, col 0) -> rom_addr=0. DrawX=56 (gap) -> pixel_on=0.
- DrawY=46, DrawX=55 (slot 0, row 38, col 39) -> rom_addr=1559. DrawY=47 -> no hit, pixel_on=0.
- Apply rom_data=FFFFFF in-slot -> pixel_on=0. Apply rom_data=EB8B7D -> pixel_on=1, pixel_rgb=EB8B7D at latency 2.
- lives 3->2 at frame_start -> blinking=1. Slot 2 visible frames 0-7, hidden 8-15, and so on. After 64 frame_start pulses -> blinking=0 and slot 2 stays hidden.
- During blink, lives 2->1 -> slots 1 and 2 blink and cnt restarts. lives 1->3 -> blinking=0 at the next frame_start with all slots solid.
- lives=7 -> clamped to 3. Assert Reset mid-line -> pixel_on=0 immediately and next frame_start shows no blink.

Source files
------------

// File: rtl/hud_pkg.sv
// Shared geometry, colour key and blink-controller types for the HUD
// remaining-lives row.
package hud_pkg;

  localparam int unsigned ICON_W       = 40;
  localparam int unsigned ICON_H       = 39;
  localparam int unsigned ICON_X0      = 16;
  localparam int unsigned ICON_Y0      = 8;
  localparam int unsigned ICON_GAP     = 8;
  localparam int unsigned ICON_PITCH   = ICON_W + ICON_GAP;
  localparam int unsigned MAX_LIVES    = 3;
  localparam int unsigned BLINK_FRAMES = 64;
  localparam int unsigned BLINK_SHIFT  = 3;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned RGB_W      = 24;
  localparam int unsigned LIVES_IN_W = 3;
  localparam int unsigned LIVES_W    = 2;
  localparam int unsigned CNT_W      = 6;

  localparam logic [RGB_W-1:0] TRANSPARENT = 24'hFFFFFF;

  typedef enum logic {IDLE, BLINK} blink_state_t;

  // Left x coordinate of icon slot k.
  function automatic logic [COORD_W-1:0] slot_x(input int unsigned k);
    return COORD_W'(ICON_X0 + k * ICON_PITCH);
  endfunction

endpackage

// File: rtl/life_blink_ctrl.sv
// Frame-synchronous life-count tracker: clamps the game's life count and
// blinks recently lost icons for a fixed number of frames.
module life_blink_ctrl
  import hud_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [LIVES_IN_W-1:0] lives,
  output logic [LIVES_W-1:0]    lives_q,
  output logic [LIVES_W-1:0]    old_q,
  output logic                  phase,
  output logic                  blinking
);

  blink_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LIVES_W-1:0] lives_d, old_d;
  logic [LIVES_W-1:0] lives_clamp;
  logic               blinking_q, blinking_d;

  // State only moves on frame_start so a frame is never drawn half old, half new.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lives_d    = lives_q;
    old_d      = old_q;
    blinking_d = (state_q == BLINK);

    lives_clamp = (lives > LIVES_IN_W'(MAX_LIVES)) ? LIVES_W'(MAX_LIVES)
                                                   : lives[LIVES_W-1:0];

    if (frame_start) begin
      case (state_q)
        IDLE: begin
          lives_d = lives_clamp;
          if (lives_clamp < lives_q) begin
            old_d   = lives_q;
            cnt_d   = '0;
            state_d = BLINK;
          end
        end
        BLINK: begin
          if (lives_clamp < lives_q) begin
            // Further loss keeps old_q, so the blinking range widens.
            lives_d = lives_clamp;
            cnt_d   = '0;
          end else if (lives_clamp > lives_q) begin
            lives_d = lives_clamp;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lives_q    <= '0;
      old_q      <= '0;
      blinking_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lives_q    <= lives_d;
      old_q      <= old_d;
      blinking_q <= blinking_d;
    end
  end

  // Inverted so a freshly lost icon is shown for the first half-period.
  assign phase    = ~cnt_q[BLINK_SHIFT];
  assign blinking = blinking_q;

endmodule

// File: rtl/life_hud_drawer.sv
// Remaining-lives HUD row: maps scan position to sprite ROM address and
// produces a transparency-keyed pixel two clocks after DrawX/DrawY.
module life_hud_drawer
  import hud_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic [LIVES_IN_W-1:0] lives,
  input  logic [COORD_W-1:0]    DrawX,
  input  logic [COORD_W-1:0]    DrawY,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [RGB_W-1:0]      rom_data,
  output logic                  pixel_on,
  output logic [RGB_W-1:0]      pixel_rgb,
  output logic                  blinking
);

  logic [LIVES_W-1:0] lives_q, old_q;
  logic               phase;

  life_blink_ctrl u_blink (
    .clk         (Clk),
    .rst         (Reset),
    .frame_start (frame_start),
    .lives       (lives),
    .lives_q     (lives_q),
    .old_q       (old_q),
    .phase       (phase),
    .blinking    (blinking)
  );

  logic [MAX_LIVES-1:0] slot_vis;
  logic                 y_hit, s0_hit, s0_vis;
  logic [COORD_W-1:0]   row, col, sx;
  logic [LIVES_W-1:0]   kk;

  // A slot is drawn if still owned, or if recently lost and in the on-phase.
  always_comb begin
    slot_vis = '0;
    kk       = '0;
    for (int unsigned k = 0; k < MAX_LIVES; k++) begin
      kk          = LIVES_W'(k);
      slot_vis[k] = (kk < lives_q) |
                    (blinking & (kk >= lives_q) & (kk < old_q) & phase);
    end
  end

  // Stage 0: slot hit test and ROM address (row*40 + col via shifts).
  always_comb begin
    s0_hit = 1'b0;
    s0_vis = 1'b0;
    col    = '0;
    sx     = '0;
    y_hit  = (DrawY >= COORD_W'(ICON_Y0)) && (DrawY < COORD_W'(ICON_Y0 + ICON_H));
    row    = DrawY - COORD_W'(ICON_Y0);
    for (int unsigned k = 0; k < MAX_LIVES; k++) begin
      sx = slot_x(k);
      if (y_hit && (DrawX >= sx) && (DrawX < sx + COORD_W'(ICON_W))) begin
        s0_hit = 1'b1;
        s0_vis = slot_vis[k];
        col    = DrawX - sx;
      end
    end
    rom_addr = s0_hit ? ((ADDR_W'(row) << 5) + (ADDR_W'(row) << 3) + ADDR_W'(col))
                      : '0;
  end

  logic             hit1_q, hit1_d;
  logic             vis1_q, vis1_d;
  logic             pixel_on_q, pixel_on_d;
  logic [RGB_W-1:0] pixel_rgb_q, pixel_rgb_d;

  // Stage 1 lines up with rom_data; the output stage applies the colour key.
  always_comb begin
    hit1_d      = s0_hit;
    vis1_d      = s0_hit & s0_vis;
    pixel_on_d  = hit1_q & vis1_q & (rom_data != TRANSPARENT);
    pixel_rgb_d = pixel_on_d ? rom_data : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit1_q      <= 1'b0;
      vis1_q      <= 1'b0;
      pixel_on_q  <= 1'b0;
      pixel_rgb_q <= '0;
    end else begin
      hit1_q      <= hit1_d;
      vis1_q      <= vis1_d;
      pixel_on_q  <= pixel_on_d;
      pixel_rgb_q <= pixel_rgb_d;
    end
  end

  assign pixel_on  = pixel_on_q;
  assign pixel_rgb = pixel_rgb_q;

endmodule

// File: tb/tb_life_hud_drawer.sv
// Scoreboard bench for life_hud_drawer: directed pixels and frame sequences,
// with a registered ROM model feeding rom_data one clock after rom_addr.
module tb_life_hud_drawer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [2:0]  lives;
  logic [9:0]  DrawX, DrawY;
  logic [10:0] rom_addr;
  logic [23:0] rom_data;
  logic        pixel_on;
  logic [23:0] pixel_rgb;
  logic        blinking;

  life_hud_drawer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .lives       (lives),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_on    (pixel_on),
    .pixel_rgb   (pixel_rgb),
    .blinking    (blinking)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        on;
    logic [23:0] rgb;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        issue, force_en;
  logic [23:0] force_val;
  logic        tag_d1, tag_d2;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Sprite ROM stand-in: a registered lookup, optionally overridden per pixel.
  always @(posedge Clk)
    rom_data <= force_en ? force_val : (24'h100000 | 24'(rom_addr));

  // Marks which output cycles correspond to an issued pixel.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tag_d1 <= 1'b0;
      tag_d2 <= 1'b0;
    end else begin
      tag_d1 <= issue;
      tag_d2 <= tag_d1;
    end
  end

  // Monitor: pop and compare whenever an issued pixel reaches the output.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && tag_d2) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk({e.name, ".on"}, 32'(pixel_on), 32'(e.on));
        chk({e.name, ".rgb"}, 32'(pixel_rgb), 32'(e.rgb));
      end
    end
  end

  task automatic pix(input int x, input int y, input logic [10:0] exp_addr,
                     input logic exp_on, input logic fen, input logic [23:0] fval,
                     input string nm);
    exp_t e;
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y);
    force_en = fen; force_val = fval; issue = 1'b1;
    #1 chk({nm, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    e.on   = exp_on;
    e.rgb  = exp_on ? (fen ? fval : (24'h100000 | 24'(exp_addr))) : 24'h0;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      issue = 1'b0; force_en = 1'b0; DrawX = 10'd700; DrawY = 10'd500;
    end
  endtask

  task automatic frame(input logic [2:0] lv);
    @(negedge Clk);
    issue = 1'b0; force_en = 1'b0; DrawX = 10'd700; DrawY = 10'd500;
    frame_start = 1'b1; lives = lv;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n, input logic [2:0] lv);
    repeat (n) frame(lv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; frame_start = 1'b0; lives = 3'd3;
    DrawX = 10'd700; DrawY = 10'd500;
    issue = 1'b0; force_en = 1'b0; force_val = 24'h0;
    repeat (3) @(negedge Clk);
    chk("rst.pixel_on", 32'(pixel_on), 32'(0));
    chk("rst.pixel_rgb", 32'(pixel_rgb), 32'(0));
    chk("rst.blinking", 32'(blinking), 32'(0));
    Reset = 1'b0;

    // No lives loaded yet: slot geometry hits but nothing is visible.
    pix(16, 8, 11'd0, 1'b0, 1'b0, 24'h0, "pre_load");
    frame(3'd3);
    idle(2);
    chk("load.blinking", 32'(blinking), 32'(0));

    pix(16, 8, 11'd0, 1'b1, 1'b0, 24'h0, "s0_origin");
    pix(64, 8, 11'd0, 1'b1, 1'b0, 24'h0, "s1_origin");
    pix(56, 8, 11'd0, 1'b0, 1'b0, 24'h0, "gap");
    pix(55, 8, 11'd39, 1'b1, 1'b0, 24'h0, "s0_right");
    pix(15, 8, 11'd0, 1'b0, 1'b0, 24'h0, "left_of_s0");
    pix(16, 7, 11'd0, 1'b0, 1'b0, 24'h0, "above_row");
    pix(55, 46, 11'd1559, 1'b1, 1'b0, 24'h0, "s0_last");
    pix(55, 47, 11'd0, 1'b0, 1'b0, 24'h0, "below_row");
    pix(112, 20, 11'd480, 1'b1, 1'b0, 24'h0, "s2_r12");
    pix(151, 46, 11'd1559, 1'b1, 1'b0, 24'h0, "s2_last");
    pix(152, 8, 11'd0, 1'b0, 1'b0, 24'h0, "right_of_s2");
    pix(20, 10, 11'd84, 1'b0, 1'b1, 24'hFFFFFF, "transparent");
    pix(20, 10, 11'd84, 1'b1, 1'b1, 24'hEB8B7D, "opaque");

    // Lose one life: slot 2 blinks 8 frames on, 8 off, for 64 frames.
    frame(3'd2);
    idle(2);
    chk("loss.blinking", 32'(blinking), 32'(1));
    pix(112, 8, 11'd0, 1'b1, 1'b0, 24'h0, "blink_cnt0");
    pix(64, 8, 11'd0, 1'b1, 1'b0, 24'h0, "blink_s1_solid");
    frames(7, 3'd2);
    pix(112, 8, 11'd0, 1'b1, 1'b0, 24'h0, "blink_cnt7");
    frames(1, 3'd2);
    pix(112, 8, 11'd0, 1'b0, 1'b0, 24'h0, "blink_cnt8");
    frames(7, 3'd2);
    pix(112, 8, 11'd0, 1'b0, 1'b0, 24'h0, "blink_cnt15");
    frames(1, 3'd2);
    pix(112, 8, 11'd0, 1'b1, 1'b0, 24'h0, "blink_cnt16");
    frames(47, 3'd2);
    idle(2);
    chk("cnt63.blinking", 32'(blinking), 32'(1));
    pix(112, 8, 11'd0, 1'b0, 1'b0, 24'h0, "blink_cnt63");
    frames(1, 3'd2);
    idle(2);
    chk("end.blinking", 32'(blinking), 32'(0));
    pix(112, 8, 11'd0, 1'b0, 1'b0, 24'h0, "after_blink_s2");
    pix(64, 8, 11'd0, 1'b1, 1'b0, 24'h0, "after_blink_s1");

    // Second loss during a blink widens the blinking range.
    frame(3'd3);
    frame(3'd2);
    frames(9, 3'd2);
    pix(112, 8, 11'd0, 1'b0, 1'b0, 24'h0, "wide_pre_cnt9");
    frame(3'd1);
    idle(2);
    chk("wide.blinking", 32'(blinking), 32'(1));
    pix(16, 8, 11'd0, 1'b1, 1'b0, 24'h0, "wide_s0");
    pix(64, 8, 11'd0, 1'b1, 1'b0, 24'h0, "wide_s1_on");
    pix(112, 8, 11'd0, 1'b1, 1'b0, 24'h0, "wide_s2_on");
    frames(8, 3'd1);
    pix(16, 8, 11'd0, 1'b1, 1'b0, 24'h0, "wide_s0_cnt8");
    pix(64, 8, 11'd0, 1'b0, 1'b0, 24'h0, "wide_s1_off");
    pix(112, 8, 11'd0, 1'b0, 1'b0, 24'h0, "wide_s2_off");
    frame(3'd3);
    idle(2);
    chk("gain.blinking", 32'(blinking), 32'(0));
    pix(16, 8, 11'd0, 1'b1, 1'b0, 24'h0, "gain_s0");
    pix(64, 8, 11'd0, 1'b1, 1'b0, 24'h0, "gain_s1");
    pix(112, 8, 11'd0, 1'b1, 1'b0, 24'h0, "gain_s2");

    // Out-of-range life counts clamp to three.
    frame(3'd1);
    frame(3'd4);
    idle(2);
    chk("clamp4.blinking", 32'(blinking), 32'(0));
    pix(112, 8, 11'd0, 1'b1, 1'b0, 24'h0, "clamp4_s2");
    frame(3'd7);
    idle(2);
    chk("clamp7.blinking", 32'(blinking), 32'(0));
    pix(112, 8, 11'd0, 1'b1, 1'b0, 24'h0, "clamp7_s2");

    // Reset with an opaque pixel at the output flushes the pipeline.
    pix(20, 10, 11'd84, 1'b1, 1'b0, 24'h0, "pre_reset");
    idle(1);
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst.pixel_on", 32'(pixel_on), 32'(0));
    chk("midrst.pixel_rgb", 32'(pixel_rgb), 32'(0));
    sb.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    idle(2);
    chk("post_rst.pixel_on", 32'(pixel_on), 32'(0));
    frame(3'd3);
    idle(2);
    chk("post_rst.blinking", 32'(blinking), 32'(0));
    pix(16, 8, 11'd0, 1'b1, 1'b0, 24'h0, "post_rst_s0");

    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
